// File: rtl/lut_const_mult_seq_if.sv
// ============================================================================
// lut_const_mult_seq_if
// ----------------------------------------------------------------------------
// Bundles the handshake and control signals of lut_const_mult_seq.
//
// Signals:
//   in_valid / in_ready / in_x        operand channel (producer -> block)
//   out_valid / out_ready / out_c     product channel (block -> consumer)
//   const_load / const_value          constant reload strobe and value
//   const_busy                        block is not idle (building or computing)
//
// Modports:
//   master  the side that feeds operands, consumes products and reloads
//           the constant
//   slave   the multiplier itself
// ============================================================================
interface lut_const_mult_seq_if #(
    parameter int DATA_W  = 8,
    parameter int CONST_W = 8
);
    logic                       in_valid;
    logic                       in_ready;
    logic [DATA_W-1:0]          in_x;

    logic                       out_valid;
    logic                       out_ready;
    logic [DATA_W+CONST_W-1:0]  out_c;

    logic                       const_load;
    logic [CONST_W-1:0]         const_value;
    logic                       const_busy;

    modport master (
        output in_valid, in_x, out_ready, const_load, const_value,
        input  in_ready, out_valid, out_c, const_busy
    );

    modport slave (
        input  in_valid, in_x, out_ready, const_load, const_value,
        output in_ready, out_valid, out_c, const_busy
    );
endinterface

// File: rtl/lut_const_mult_seq.sv
// ============================================================================
// lut_const_mult_seq
// ----------------------------------------------------------------------------
// Digit-serial unsigned multiplier: out_c = in_x * A, where A is a
// runtime-loadable constant. The operand is consumed one radix-16 digit per
// cycle after signed recoding (digits in -8..7), so every partial product is
// +/- k*A with k in 0..8. Those nine multiples live in a small LUT that the
// block fills itself, one entry per cycle, after reset and after each
// constant reload.
//
// Parameters:
//   DATA_W   operand width, multiple of 4 and >= 8 (NDIG = DATA_W/4 digits)
//   CONST_W  constant width, >= 2
//   A_CONST  constant restored by reset
//
// Ports:
//   clk   rising-edge clock
//   rst   synchronous, active-high reset
//   bus   lut_const_mult_seq_if.slave
//           in_valid/in_ready/in_x        operand handshake
//           out_valid/out_ready/out_c     product handshake
//           const_load/const_value        constant reload (honoured in IDLE)
//           const_busy                    high in every state except IDLE
//
// Latency: operand accepted at edge E0, product valid after E(NDIG+1).
// All handshake outputs are decoded from the state register, so there is no
// combinational path from in_valid/out_ready to in_ready/out_valid.
// ============================================================================
module lut_const_mult_seq #(
    parameter int DATA_W  = 8,
    parameter int CONST_W = 8,
    parameter int A_CONST = 2
) (
    input  logic                clk,
    input  logic                rst,
    lut_const_mult_seq_if.slave bus
);
    localparam int NDIG  = DATA_W / 4;
    localparam int LUT_W = CONST_W + 4;         // holds up to 8*A
    localparam int ACC_W = DATA_W + CONST_W + 1; // one sign bit above product
    localparam int OUT_W = DATA_W + CONST_W;
    localparam int IDX_W = $clog2(NDIG + 1);

    // Digit index NDIG is the extra cycle that folds in the final carry.
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NDIG);

    typedef enum logic [1:0] {
        BUILD,
        IDLE,
        CALC,
        DONE
    } state_t;

    state_t state;
    state_t state_next;

    // ------------------------------------------------------------------------
    // Datapath state
    // ------------------------------------------------------------------------
    logic [CONST_W-1:0]       a_reg;      // current constant A
    logic [LUT_W-1:0]         lut [0:8];  // lut[k] = k * A
    logic [3:0]               build_k;    // LUT entry written this BUILD cycle
    logic [DATA_W-1:0]        x_sr;       // operand, shifted right a digit per step
    logic [IDX_W-1:0]         dig_idx;    // digit currently being processed
    logic                     carry;      // recoding carry into the next digit
    logic signed [ACC_W-1:0]  acc;        // running signed sum of partial products
    logic [OUT_W-1:0]         out_c_reg;

    // ------------------------------------------------------------------------
    // Digit recoding and accumulator update
    // ------------------------------------------------------------------------
    // t = digit + carry lies in 0..16. Values 8..16 are rewritten as t-16
    // (a negative digit of magnitude 16-t) and push a carry of 1 into the
    // next digit, so the LUT never needs more than 8*A.
    logic [4:0]               digit_t;
    logic                     digit_neg;
    logic [3:0]               digit_mag;
    logic signed [ACC_W-1:0]  term;
    logic signed [ACC_W-1:0]  acc_next;

    // NOTE: every variable written in an always_comb block gets a default
    // first, so no path through the block can leave it unassigned and infer
    // a latch.
    always_comb begin
        digit_t   = {1'b0, x_sr[3:0]} + {4'b0000, carry};
        digit_neg = (digit_t >= 5'd8);
        digit_mag = digit_neg ? 4'(5'd16 - digit_t) : digit_t[3:0];
        term      = '0;
        acc_next  = acc;

        if (dig_idx == LAST_IDX) begin
            // Final step: the outgoing carry weighs 16^NDIG, i.e. 1*A << DATA_W.
            term = ACC_W'(lut[1]) << DATA_W;
            if (carry) begin
                acc_next = acc + term;
            end
        end else begin
            // Digit i weighs 16^i; lut[0] is zero, so d = 0 adds nothing.
            term     = ACC_W'(lut[digit_mag]) << {dig_idx, 2'b00};
            acc_next = digit_neg ? (acc - term) : (acc + term);
        end
    end

    // ------------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------------
    // NOTE: clocked processes use non-blocking assignments only, so every
    // register samples the values from before the edge regardless of the
    // order the statements are written in.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= BUILD;
        end else begin
            state <= state_next;
        end
    end

    // ------------------------------------------------------------------------
    // FSM: next state and state-decoded outputs
    // ------------------------------------------------------------------------
    always_comb begin
        state_next     = state;
        bus.in_ready   = 1'b0;
        bus.out_valid  = 1'b0;
        bus.const_busy = 1'b1;

        case (state)
            BUILD: begin
                if (build_k == 4'd8) begin
                    state_next = IDLE;
                end
            end

            IDLE: begin
                bus.in_ready   = 1'b1;
                bus.const_busy = 1'b0;
                // A reload wins over an operand offered in the same cycle.
                if (bus.const_load) begin
                    state_next = BUILD;
                end else if (bus.in_valid) begin
                    state_next = CALC;
                end
            end

            CALC: begin
                if (dig_idx == LAST_IDX) begin
                    state_next = DONE;
                end
            end

            DONE: begin
                bus.out_valid = 1'b1;
                if (bus.out_ready) begin
                    state_next = IDLE;
                end
            end

            default: begin
                state_next = BUILD;
            end
        endcase
    end

    assign bus.out_c = out_c_reg;

    // ------------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------------
    // NOTE: only lut[0] is reset. Entries 1..8 are always rewritten by the
    // BUILD pass that follows reset before anything reads them, so they are
    // left as plain storage without a reset path.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_reg     <= CONST_W'(A_CONST);
            lut[0]    <= '0;
            build_k   <= 4'd1;
            x_sr      <= '0;
            dig_idx   <= '0;
            carry     <= 1'b0;
            acc       <= '0;
            out_c_reg <= '0;
        end else begin
            case (state)
                BUILD: begin
                    // After a reload the pass starts at k=0, re-clearing
                    // lut[0]; after reset it starts at k=1 because reset
                    // already cleared it. A reload therefore spends one more
                    // cycle in BUILD than a reset does.
                    if (build_k == 4'd0) begin
                        lut[0] <= '0;
                    end else begin
                        lut[build_k] <= lut[build_k - 4'd1] + LUT_W'(a_reg);
                    end
                    build_k <= build_k + 4'd1;
                end

                IDLE: begin
                    if (bus.const_load) begin
                        a_reg   <= bus.const_value;
                        build_k <= 4'd0;
                    end else if (bus.in_valid) begin
                        x_sr    <= bus.in_x;
                        acc     <= '0;
                        carry   <= 1'b0;
                        dig_idx <= '0;
                    end
                end

                CALC: begin
                    acc <= acc_next;
                    if (dig_idx == LAST_IDX) begin
                        // Final value is non-negative and fits OUT_W bits,
                        // so the sign bit is simply dropped.
                        out_c_reg <= acc_next[OUT_W-1:0];
                    end else begin
                        carry   <= digit_neg;
                        x_sr    <= x_sr >> 4;
                        dig_idx <= dig_idx + 1'b1;
                    end
                end

                DONE: begin
                    // Product held in out_c_reg until the consumer takes it.
                end

                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lut_const_mult_seq.sv
// ============================================================================
// tb_lut_const_mult_seq
// ----------------------------------------------------------------------------
// Self-checking bench for lut_const_mult_seq. Two instances: an 8-bit operand
// build (A_CONST=2) and a 16-bit operand build. Expected products are plain
// integer multiplications x*A; expected timing is taken from the block's
// documented cycle counts.
// ============================================================================
module tb_lut_const_mult_seq;
    localparam int DW    = 8;
    localparam int CW    = 8;
    localparam int NDIG  = DW / 4;
    localparam int DW16  = 16;
    localparam int NDIG16 = DW16 / 4;

    logic clk = 1'b0;
    logic rst = 1'b1;

    int checks = 0;
    int errors = 0;

    // Reference model state: the constant each instance should be using.
    int unsigned a_model   = 2;
    int unsigned a16_model = 2;

    lut_const_mult_seq_if #(.DATA_W(DW),   .CONST_W(CW)) bus ();
    lut_const_mult_seq_if #(.DATA_W(DW16), .CONST_W(CW)) bus16 ();

    lut_const_mult_seq #(.DATA_W(DW), .CONST_W(CW), .A_CONST(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    lut_const_mult_seq #(.DATA_W(DW16), .CONST_W(CW), .A_CONST(2)) dut16 (
        .clk (clk),
        .rst (rst),
        .bus (bus16)
    );

    always #5 clk = ~clk;

    // Advance one clock; inputs are driven and outputs sampled 1 ns after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready(input string name);
        int n = 0;
        while (!bus.in_ready && n < 50) begin
            step();
            n++;
        end
        checks++;
        if (bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s: in_ready timeout, got %b want 1", name, bus.in_ready);
        end
    endtask

    // One full transaction on the 8-bit instance, checking latency, product
    // and the return to IDLE after the handshake.
    task automatic run_op(input logic [7:0] x, input string name);
        logic [15:0] expv;
        int lat;
        expv = 16'(x * a_model);
        wait_ready(name);
        bus.in_x     = x;
        bus.in_valid = 1'b1;
        step();
        bus.in_valid = 1'b0;
        bus.in_x     = 8'($urandom);
        lat = 0;
        while (!bus.out_valid && lat < 20) begin
            step();
            lat++;
        end
        checks++;
        if (lat !== NDIG + 1) begin
            errors++;
            $display("FAIL %s latency: got %0d want %0d", name, lat, NDIG + 1);
        end
        checks++;
        if (bus.out_c !== expv) begin
            errors++;
            $display("FAIL %s product x=%0d A=%0d: got %0d want %0d",
                     name, x, a_model, bus.out_c, expv);
        end
        bus.out_ready = 1'b1;
        step();
        bus.out_ready = 1'b0;
        checks++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s release: got out_valid=%b in_ready=%b want 0/1",
                     name, bus.out_valid, bus.in_ready);
        end
    endtask

    // Count the cycles in_ready stays low after a reload strobe (or reset).
    task automatic count_busy(input string name, input int want);
        int n = 0;
        while (!bus.in_ready && n < 30) begin
            n++;
            step();
        end
        checks++;
        if (n !== want) begin
            errors++;
            $display("FAIL %s busy cycles: got %0d want %0d", name, n, want);
        end
        checks++;
        if (bus.const_busy !== 1'b0) begin
            errors++;
            $display("FAIL %s const_busy in IDLE: got %b want 0", name, bus.const_busy);
        end
    endtask

    task automatic load_const(input logic [7:0] a, input string name);
        wait_ready(name);
        bus.const_load  = 1'b1;
        bus.const_value = a;
        step();
        bus.const_load  = 1'b0;
        a_model = a;
        checks++;
        if (bus.const_busy !== 1'b1) begin
            errors++;
            $display("FAIL %s const_busy after load: got %b want 1", name, bus.const_busy);
        end
        count_busy(name, 9);
    endtask

    // ------------------------------------------------------------------------
    task automatic test_reset();
        checks++;
        if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b0 ||
            bus.out_c !== 16'd0 || bus.const_busy !== 1'b1) begin
            errors++;
            $display("FAIL reset_state: got in_ready=%b out_valid=%b out_c=%0d const_busy=%b want 0/0/0/1",
                     bus.in_ready, bus.out_valid, bus.out_c, bus.const_busy);
        end
        rst = 1'b0;
        count_busy("reset_build", 8);
    endtask

    task automatic test_basic();
        a_model = 2;
        run_op(8'hFF, "basic_ff");
        run_op(8'h88, "basic_88");   // digit 8 recodes to -8, uses lut[8]=16
        run_op(8'h01, "basic_01");
    endtask

    task automatic test_recoding();
        load_const(8'd13, "load13");
        run_op(8'h9C, "rec_9c");     // 2028
        run_op(8'h88, "rec_88");     // 1768
        run_op(8'h00, "rec_00");     // 0
        run_op(8'h7F, "rec_7f");
    endtask

    task automatic test_max();
        load_const(8'd255, "load255");
        run_op(8'hFF, "max_ff");     // 0xFE01
        run_op(8'h80, "max_80");
    endtask

    task automatic test_random();
        for (int r = 0; r < 5; r++) begin
            logic [7:0] a;
            a = (r == 0) ? 8'd0 : (r == 1) ? 8'd1 : 8'($urandom);
            load_const(a, "rand_load");
            for (int k = 0; k < 6; k++) begin
                run_op(8'($urandom), "rand_op");
            end
        end
    endtask

    task automatic test_backpressure();
        logic [15:0] expv;
        int lat = 0;
        load_const(8'd77, "bp_load");
        expv = 16'(8'hB5 * a_model);
        wait_ready("bp");
        bus.in_x = 8'hB5;
        bus.in_valid = 1'b1;
        step();
        bus.in_valid = 1'b0;
        while (!bus.out_valid && lat < 20) begin
            step();
            lat++;
        end
        // Hold the product while offering a stray operand, which must be ignored.
        bus.in_valid = 1'b1;
        bus.in_x     = 8'h11;
        for (int c = 0; c < 5; c++) begin
            step();
            checks++;
            if (bus.out_valid !== 1'b1 || bus.out_c !== expv || bus.in_ready !== 1'b0) begin
                errors++;
                $display("FAIL bp_hold cycle %0d: got out_valid=%b out_c=%0d in_ready=%b want 1/%0d/0",
                         c, bus.out_valid, bus.out_c, bus.in_ready, expv);
            end
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        step();
        bus.out_ready = 1'b0;
        checks++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.out_c !== expv) begin
            errors++;
            $display("FAIL bp_release: got out_valid=%b in_ready=%b out_c=%0d want 0/1/%0d",
                     bus.out_valid, bus.in_ready, bus.out_c, expv);
        end
    endtask

    task automatic test_collisions();
        logic [15:0] expv;
        int lat = 0;
        load_const(8'd13, "col_load");
        // Reload strobe during CALC must be ignored.
        expv = 16'(8'h9C * a_model);
        wait_ready("col_calc");
        bus.in_x = 8'h9C;
        bus.in_valid = 1'b1;
        step();
        bus.in_valid    = 1'b0;
        bus.const_load  = 1'b1;
        bus.const_value = 8'd200;
        step();
        bus.const_load  = 1'b0;
        lat = 1;
        while (!bus.out_valid && lat < 20) begin
            step();
            lat++;
        end
        checks++;
        if (bus.out_c !== expv) begin
            errors++;
            $display("FAIL col_calc_old_a: got %0d want %0d", bus.out_c, expv);
        end
        bus.out_ready = 1'b1;
        step();
        bus.out_ready = 1'b0;
        checks++;
        if (bus.in_ready !== 1'b1 || bus.const_busy !== 1'b0) begin
            errors++;
            $display("FAIL col_calc_no_build: got in_ready=%b const_busy=%b want 1/0",
                     bus.in_ready, bus.const_busy);
        end
        run_op(8'h55, "col_after_ignored");

        // Reload and operand in the same IDLE cycle: reload wins.
        bus.const_load  = 1'b1;
        bus.const_value = 8'd3;
        bus.in_valid    = 1'b1;
        bus.in_x        = 8'hAA;
        step();
        bus.const_load = 1'b0;
        bus.in_valid   = 1'b0;
        a_model = 3;
        checks++;
        if (bus.const_busy !== 1'b1 || bus.in_ready !== 1'b0) begin
            errors++;
            $display("FAIL col_both: got const_busy=%b in_ready=%b want 1/0",
                     bus.const_busy, bus.in_ready);
        end
        count_busy("col_both_build", 9);
        checks++;
        if (bus.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL col_both_no_op: got out_valid=%b want 0", bus.out_valid);
        end
        run_op(8'hAA, "col_new_a");
    endtask

    task automatic test_back_to_back();
        logic [15:0] q_exp[$];
        int last_acc = -1;
        int outs = 0;
        int cyc  = 0;
        bit acc_now;
        load_const(8'($urandom_range(1, 255)), "b2b_load");
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        bus.in_x      = 8'($urandom);
        while (outs < 6 && cyc < 100) begin
            acc_now = bus.in_ready && bus.in_valid;
            if (acc_now) begin
                q_exp.push_back(16'(bus.in_x * a_model));
                if (last_acc >= 0) begin
                    checks++;
                    if (cyc - last_acc !== NDIG + 3) begin
                        errors++;
                        $display("FAIL b2b_interval: got %0d want %0d", cyc - last_acc, NDIG + 3);
                    end
                end
                last_acc = cyc;
            end
            if (bus.out_valid) begin
                checks++;
                if (q_exp.size() == 0) begin
                    errors++;
                    $display("FAIL b2b_spurious: got out_valid=1 want 0");
                end else if (bus.out_c !== q_exp[0]) begin
                    errors++;
                    $display("FAIL b2b_product: got %0d want %0d", bus.out_c, q_exp[0]);
                end
                if (q_exp.size() != 0) begin
                    void'(q_exp.pop_front());
                end
                outs++;
            end
            step();
            cyc++;
            if (acc_now) begin
                bus.in_x = 8'($urandom);
            end
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        checks++;
        if (outs !== 6) begin
            errors++;
            $display("FAIL b2b_count: got %0d products want 6", outs);
        end
        step();
    endtask

    task automatic test_reset_mid();
        load_const(8'd100, "mid_load");
        wait_ready("mid");
        bus.in_x = 8'hC3;
        bus.in_valid = 1'b1;
        step();
        bus.in_valid = 1'b0;
        step();
        rst = 1'b1;
        step();
        checks++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b0 ||
            bus.const_busy !== 1'b1 || bus.out_c !== 16'd0) begin
            errors++;
            $display("FAIL mid_reset: got out_valid=%b in_ready=%b const_busy=%b out_c=%0d want 0/0/1/0",
                     bus.out_valid, bus.in_ready, bus.const_busy, bus.out_c);
        end
        rst = 1'b0;
        a_model   = 2;
        a16_model = 2;
        count_busy("mid_rebuild", 8);
        run_op(8'd3, "mid_after");   // 6 with A restored to 2
    endtask

    task automatic run_op16(input logic [15:0] x, input string name);
        logic [23:0] expv;
        int lat = 0;
        int n = 0;
        expv = 24'(x * a16_model);
        while (!bus16.in_ready && n < 50) begin
            step();
            n++;
        end
        bus16.in_x     = x;
        bus16.in_valid = 1'b1;
        step();
        bus16.in_valid = 1'b0;
        while (!bus16.out_valid && lat < 30) begin
            step();
            lat++;
        end
        checks++;
        if (lat !== NDIG16 + 1 || bus16.out_c !== expv) begin
            errors++;
            $display("FAIL %s: got latency %0d out_c %0h want %0d / %0h",
                     name, lat, bus16.out_c, NDIG16 + 1, expv);
        end
        bus16.out_ready = 1'b1;
        step();
        bus16.out_ready = 1'b0;
    endtask

    task automatic test_wide();
        int n = 0;
        while (!bus16.in_ready && n < 50) begin
            step();
            n++;
        end
        bus16.const_load  = 1'b1;
        bus16.const_value = 8'hFF;
        step();
        bus16.const_load = 1'b0;
        a16_model = 255;
        n = 0;
        while (!bus16.in_ready && n < 30) begin
            n++;
            step();
        end
        checks++;
        if (n !== 9) begin
            errors++;
            $display("FAIL wide_load busy cycles: got %0d want 9", n);
        end
        run_op16(16'hFFFF, "wide_max");   // 0xFEFF01
        run_op16(16'h8888, "wide_8888");
        for (int k = 0; k < 4; k++) begin
            run_op16(16'($urandom), "wide_rand");
        end
    endtask

    // ------------------------------------------------------------------------
    initial begin
        bus.in_valid      = 1'b0;
        bus.in_x          = '0;
        bus.out_ready     = 1'b0;
        bus.const_load    = 1'b0;
        bus.const_value   = '0;
        bus16.in_valid    = 1'b0;
        bus16.in_x        = '0;
        bus16.out_ready   = 1'b0;
        bus16.const_load  = 1'b0;
        bus16.const_value = '0;
        rst = 1'b1;
        step();
        step();

        test_reset();
        test_basic();
        test_recoding();
        test_max();
        test_random();
        test_backpressure();
        test_collisions();
        test_back_to_back();
        test_reset_mid();
        test_wide();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/lut_const_mult_seq.md
# lut_const_mult_seq

Digit-serial, parametrised successor to the 8-bit LUT constant multiplier. It multiplies an unsigned DATA_W-bit operand by a runtime-loadable unsigned constant. The operand is processed one radix-16 signed-recoded digit per cycle, using a 9-word multiple LUT (0..8 × A) that the block builds itself. It sits between an upstream producer and a downstream consumer, with valid/ready handshakes on both sides.

## Interface
- DATA_W, 8: operand width; must be a multiple of 4, ≥ 8. NDIG = DATA_W/4.
- CONST_W, 8: constant width, ≥ 2.
- A_CONST, 2: constant loaded by reset; must fit in CONST_W bits.
- clk  in  1  sole clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  operand offered.
- in_ready  out  1  block accepts operand this cycle.
- in_x  in  DATA_W  unsigned operand.
- out_valid  out  1  product available.
- out_ready  in  1  consumer takes product.
- out_c  out  DATA_W+CONST_W  unsigned product in_x × A.
- const_load  in  1  request new constant (one-cycle strobe).
- const_value  in  CONST_W  new constant.
- const_busy  out  1  high whenever state ≠ IDLE.

## Operation
- States: BUILD, IDLE, CALC, DONE.
- Reset: state=BUILD, A=A_CONST, in_ready=0, out_valid=0, out_c=0, const_busy=1, accumulator=0, LUT[0]=0.
- BUILD: for 8 cycles (k=1..8), LUT[k] = LUT[k-1] + A, one entry per cycle. Then go to IDLE. LUT word width is CONST_W+4.
- IDLE: in_ready=1, const_busy=0.
  - If const_load=1: latch A=const_value and go to BUILD. const_load has priority over in_valid. in_ready is still 1 in that cycle, but the operand is not accepted.
  - Else if in_valid=1: latch in_x into the shift register, clear the accumulator, set carry=0, digit index i=0, and go to CALC.
- const_load outside IDLE is ignored; no queuing.
- CALC, per cycle for i=0..NDIG-1:
  - t = x[4i+3:4i] + carry, range 0..16.
  - If t ≥ 8: d = t−16 (range −8..0), carry=1. Else d = t, carry=0.
  - acc += sign(d) × (LUT[|d|] << 4i).
- CALC, cycle i=NDIG: acc += carry × (LUT[1] << 4·NDIG). Then out_c = acc[DATA_W+CONST_W-1:0], out_valid=1, go to DONE.
- Accumulator: signed, DATA_W+CONST_W+1 bits. Intermediate values may be negative; the final value is always non-negative and fits in out_c.
- DONE: out_valid=1, out_c held stable, in_ready=0. On out_ready=1: out_valid=0 next cycle, go to IDLE. out_c keeps its last value.
- Reset in any state aborts the operation. It drops out_valid, reverts A to A_CONST and re-enters BUILD.

## Timing
- Reset to first in_ready=1: 8 cycles after the cycle rst is released.
- const_load accepted at edge E: const_busy=1 from E. in_ready returns after E+9.
- Operand accepted at edge E0. Digit steps occur at E1..E(NDIG+1). out_valid is high after E(NDIG+1), i.e. NDIG+1 cycles of latency (3 for DATA_W=8).
- out_valid with out_ready held high: 1 cycle in DONE. in_ready is high the following cycle. Minimum accept-to-accept interval is NDIG+3 cycles.
- out_ready is ignored outside DONE. in_valid is ignored outside IDLE.
- No combinational path from in_valid/out_ready to in_ready/out_valid. All outputs are registered or decoded from state.

## Test plan
- Reset, DATA_W=8, A_CONST=2: wait for in_ready, send in_x=0xFF → out_c=510 (0x01FE) exactly 3 cycles after accept; LUT[8]=16.
- Recoding and carry chain: const_load A=13, then in_x=0x9C (digits −4, −6, final carry 1) → out_c=2028; in_x=0x88 → 1768; in_x=0x00 → 0.
- Max values: A=255, in_x=0xFF → out_c=0xFE01. Separate DATA_W=16 build with A=0xFF, in_x=0xFFFF → out_c=0xFEFF01.
- Backpressure: hold out_ready=0 for 5 cycles in DONE → out_valid stays 1, out_c stable, in_ready=0. Raise out_ready → out_valid=0 next cycle, in_ready=1.
- Control collisions: const_load=1 during CALC → ignored, current result uses the old A. const_load and in_valid together in IDLE → load wins, operand not accepted, in_ready=0 for 9 cycles.
- Reset mid-CALC after loading A=100 → out_valid=0, BUILD restarts. Next in_x=3 → out_c=6 (A_CONST=2).
